// File: rtl/axi_bridge_arbiter_pkg.sv
// Package: shared types and helpers for the AXI bridge round-robin arbiter.
//   arb_state_t : arbiter FSM states
//   id_w()      : width of a requester index (at least 1 bit)
package axi_bridge_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_bridge_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req       in  NUM_REQ  request vector
//   ptr       in  IW       highest-priority index this round
//   winner    out IW       first asserted index at or above ptr, wrapping
//   any_valid out 1        at least one request asserted
module rr_pick
    import axi_bridge_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IW      = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      winner,
    output logic               any_valid
);

    int idx;

    // Scan from the farthest offset back towards ptr so the closest
    // asserted request (in wrap order) is the last assignment and wins.
    always_comb begin
        winner    = '0;
        any_valid = |req;
        idx       = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) winner = IW'(idx);
        end
    end

endmodule

// File: rtl/axi_bridge_arbiter.sv
// axi_bridge_arbiter: round-robin sharing of the bridge's single internal
// port between NUM_REQ requesters. One transaction in flight at a time.
//   clk, rst                 clock, async active-high reset
//   s_req/s_we/s_addr/s_wdata requester side (flattened, requester i at slice i)
//   s_ack, s_rdata           one-hot completion pulse and broadcast read data
//   m_req/m_we/m_addr/m_wdata request to bridge, held until m_ack
//   m_ack, m_rdata           completion pulse and read data from bridge
//   grant_id, busy           current/last grant, transaction in flight
//   timeout_err, err_clr     sticky cycle-budget overrun flag and its clear
module axi_bridge_arbiter
    import axi_bridge_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 3,
    parameter int TIMEOUT    = 1024,
    localparam int IW        = id_w(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            s_req,
    input  logic [NUM_REQ-1:0]            s_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] s_wdata,
    output logic [NUM_REQ-1:0]            s_ack,
    output logic [DATA_WIDTH-1:0]         s_rdata,
    output logic                          m_req,
    output logic                          m_we,
    output logic [ADDR_WIDTH-1:0]         m_addr,
    output logic [DATA_WIDTH-1:0]         m_wdata,
    input  logic                          m_ack,
    input  logic [DATA_WIDTH-1:0]         m_rdata,
    output logic [IW-1:0]                 grant_id,
    output logic                          busy,
    output logic                          timeout_err,
    input  logic                          err_clr
);

    localparam int CW = $clog2(TIMEOUT);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    logic [IW-1:0] pick;
    logic          any_req;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req       (s_req),
        .ptr       (rr_ptr_q),
        .winner    (pick),
        .any_valid (any_req)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        // Clear first so a same-cycle set below overrides it.
        err_d    = err_clr ? 1'b0 : err_q;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
        s_ack    = '0;
        s_rdata  = '0;
        busy     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                // m_ack here is spurious and deliberately ignored.
                if (any_req) begin
                    grant_d = pick;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                // Held regardless of s_req: the bridge has already latched it.
                m_req   = 1'b1;
                busy    = 1'b1;
                m_we    = s_we[grant_q];
                m_addr  = s_addr[int'(grant_q)*ADDR_WIDTH +: ADDR_WIDTH];
                m_wdata = s_wdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
                if (m_ack) begin
                    s_ack[grant_q] = 1'b1;
                    s_rdata        = m_rdata;
                    rr_ptr_d       = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                    state_d        = ARB_IDLE;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d = 1'b1;   // counter saturates here
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign grant_id    = grant_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_axi_bridge_arbiter.sv
// Directed bench for axi_bridge_arbiter (NUM_REQ=3, TIMEOUT=16). Inputs are
// driven 2 time units after each rising edge and outputs sampled 1 unit later.
module tb_axi_bridge_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    s_req = '0;
    logic [NR-1:0]    s_we = '0;
    logic [NR*AW-1:0] s_addr = '0;
    logic [NR*DW-1:0] s_wdata = '0;
    logic [NR-1:0]    s_ack;
    logic [DW-1:0]    s_rdata;
    logic             m_req, m_we;
    logic [AW-1:0]    m_addr;
    logic [DW-1:0]    m_wdata;
    logic             m_ack = 1'b0;
    logic [DW-1:0]    m_rdata = '0;
    logic [1:0]       grant_id;
    logic             busy, timeout_err;
    logic             err_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    axi_bridge_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .grant_id(grant_id), .busy(busy),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin : stim
        logic [1:0] exp_g [4];
        exp_g[0] = 2'd0; exp_g[1] = 2'd1; exp_g[2] = 2'd2; exp_g[3] = 2'd0;

        // Reset state
        tick(); tick();
        #1;
        chk("rst_m_req", m_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_terr", timeout_err, 0);
        chk("rst_s_ack", s_ack, 0);
        chk("rst_m_addr", m_addr, 0);
        rst = 1'b0;

        // 1: single write on requester 1, ack 4 cycles after m_req
        tick();
        s_req = 3'b010; s_we = 3'b010;
        s_addr[1*AW +: AW] = 32'h1000_0040;
        s_wdata[1*DW +: DW] = 32'hDEAD_BEEF;
        #1 chk("t1_latency", m_req, 0);
        tick(); #1;
        chk("t1_m_req", m_req, 1);
        chk("t1_grant", grant_id, 1);
        chk("t1_m_addr", m_addr, 32'h1000_0040);
        chk("t1_m_wdata", m_wdata, 32'hDEAD_BEEF);
        chk("t1_m_we", m_we, 1);
        chk("t1_no_ack", s_ack, 0);
        tick(); tick(); tick(); tick();
        m_ack = 1'b1;
        #1 chk("t1_s_ack", s_ack, 3'b010);
        tick();
        m_ack = 1'b0; s_req = 3'b000; s_we = 3'b000;
        #1;
        chk("t1_ack_once", s_ack, 0);
        chk("t1_m_req_low", m_req, 0);

        // 3: read on requester 2; requester 0 also asks, so a grant to 2
        // shows rr_ptr advanced to 2 after the previous grant to 1.
        s_req = 3'b101;
        s_addr[2*AW +: AW] = 32'h2000_0008;
        tick(); #1;
        chk("t3_grant_ptr2", grant_id, 2);
        chk("t3_m_addr", m_addr, 32'h2000_0008);
        chk("t3_m_we", m_we, 0);
        s_req = 3'b100;
        tick();
        m_ack = 1'b1; m_rdata = 32'h1234_5678;
        #1;
        chk("t3_s_rdata", s_rdata, 32'h1234_5678);
        chk("t3_s_ack", s_ack, 3'b100);
        tick();
        m_ack = 1'b0; s_req = 3'b000;
        #1;
        chk("t3_rdata_zero", s_rdata, 0);
        chk("t3_ack_zero", s_ack, 0);

        // 2: all three request continuously, ack 3 cycles after m_req
        s_addr[0*AW +: AW] = 32'hA000_0000;
        s_addr[1*AW +: AW] = 32'hA000_0010;
        s_addr[2*AW +: AW] = 32'hA000_0020;
        s_req = 3'b111;
        #1 chk("t2_idle", m_req, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("t2_grant", grant_id, exp_g[k]);
            chk("t2_m_req", m_req, 1);
            chk("t2_m_addr", m_addr, 64'hA000_0000 + 64'(exp_g[k]) * 16);
            tick(); tick(); tick();
            m_ack = 1'b1;
            #1 chk("t2_s_ack", s_ack, 3'b001 << exp_g[k]);
            tick();
            m_ack = 1'b0;
            if (k == 3) s_req = 3'b000;
            #1 chk("t2_gap", m_req, 0);
        end

        // 4: timeout on requester 1 (rr_ptr now 1); err_clr in the set cycle loses
        s_req = 3'b010;
        tick(); #1;
        chk("t4_grant", grant_id, 1);
        chk("t4_terr_b1", timeout_err, 0);
        for (int n = 0; n < 15; n++) tick();
        err_clr = 1'b1;
        #1 chk("t4_terr_b16", timeout_err, 0);
        tick();
        err_clr = 1'b0;
        #1;
        chk("t4_terr_set", timeout_err, 1);
        chk("t4_m_req_held", m_req, 1);
        tick(); tick();
        m_ack = 1'b1;
        #1 chk("t4_late_ack", s_ack, 3'b010);
        tick();
        m_ack = 1'b0; s_req = 3'b000;
        #1 chk("t4_sticky", timeout_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        #1 chk("t4_cleared", timeout_err, 0);

        // 5: requester 0 drops s_req mid-transaction
        s_addr[0*AW +: AW] = 32'hC000_0004;
        s_req = 3'b001;
        tick(); #1;
        chk("t5_grant", grant_id, 0);
        tick(); tick();
        s_req = 3'b000;
        tick(); #1;
        chk("t5_m_req_held", m_req, 1);
        chk("t5_m_addr_held", m_addr, 32'hC000_0004);
        m_ack = 1'b1;
        #1 chk("t5_s_ack", s_ack, 3'b001);
        tick();
        // spurious ack while idle
        #1 chk("t5_spur_ack", s_ack, 0);
        m_ack = 1'b0;
        tick(); #1;
        chk("t5_idle_busy", busy, 0);

        // 6: async reset while busy
        s_req = 3'b001;
        tick(); #1;
        chk("t6_busy", busy, 1);
        rst = 1'b1; m_ack = 1'b1;
        #1;
        chk("t6_rst_m_req", m_req, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_s_ack", s_ack, 0);
        m_ack = 1'b0; s_req = 3'b100;
        tick();
        rst = 1'b0;
        tick(); #1;
        chk("t6_grant2", grant_id, 2);
        chk("t6_m_req", m_req, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_bridge_arbiter.md
Name: axi_bridge_arbiter

Overview:
- Round-robin arbiter sharing the single internal port of the AXI4-Lite master bridge between NUM_REQ requesters (e.g. I-fetch, D-mem, DMA).
- Sits between the interconnect requesters and the bridge.
- Grants one transaction at a time and holds the bridge request until the bridge acks.
- Routes the ack and read data back to the granted requester, and flags transactions that exceed a cycle budget.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, data width.
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT, 1024, BUSY cycles before timeout_err sets (>=2).

Ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- s_req  in  NUM_REQ  per-requester request; held until its s_ack
- s_we  in  NUM_REQ  per-requester write enable
- s_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at slice i
- s_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
- s_ack  out  NUM_REQ  one-hot single-cycle completion
- s_rdata  out  DATA_WIDTH  read data, valid with s_ack, broadcast
- m_req  out  1  to bridge internal_req
- m_we  out  1  to bridge internal_we
- m_addr  out  ADDR_WIDTH  to bridge internal_addr
- m_wdata  out  DATA_WIDTH  to bridge internal_wdata
- m_ack  in  1  from bridge internal_ack (one-cycle pulse)
- m_rdata  in  DATA_WIDTH  from bridge internal_rdata
- grant_id  out  $clog2(NUM_REQ)  current or last granted index
- busy  out  1  transaction in flight
- timeout_err  out  1  sticky timeout flag
- err_clr  in  1  clears timeout_err

Behaviour:
- Reset (rst=1, async): state ARB_IDLE, rr_ptr=0, grant_id=0, timeout counter=0, timeout_err=0. All outputs 0: m_req, m_we, m_addr, m_wdata, s_ack, s_rdata, busy.
- States: ARB_IDLE, ARB_BUSY.
- ARB_IDLE:
  - m_req=0.
  - If any s_req: winner = first asserted index scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register winner into grant_id; go ARB_BUSY next cycle.
  - Arbitration latency: one cycle from s_req to m_req.
- ARB_BUSY:
  - m_req=1, busy=1.
  - m_we, m_addr, m_wdata muxed combinationally from requester grant_id.
  - On m_ack: s_ack[grant_id]=1 and s_rdata=m_rdata in the same cycle (combinational pass-through). rr_ptr <= (grant_id+1) mod NUM_REQ; next state ARB_IDLE.
- Back-to-back: m_req is always 0 for at least one cycle after m_ack, so the bridge never re-samples a completed request. Minimum transaction spacing is ack cycle + 1 idle/arb cycle.
- Protocol violation: if the granted requester drops s_req while in ARB_BUSY, the arbiter still holds m_req, the grant and the muxed fields until m_ack, then delivers s_ack[grant_id]. It never aborts, because the bridge has already latched the request.
- Non-granted requesters: s_ack stays 0; their s_req is ignored until ARB_IDLE.
- s_ack and s_rdata are 0 in all cycles except the ack cycle.
- Timeout:
  - Counter clears on entry to ARB_BUSY and increments each ARB_BUSY cycle without m_ack.
  - When it reaches TIMEOUT-1 without m_ack, timeout_err sets (sticky); the counter saturates.
  - The transaction continues waiting; no forced completion.
- err_clr clears timeout_err next cycle. If err_clr coincides with a set condition, the set wins.
- m_ack while in ARB_IDLE is spurious: ignored, no s_ack.
- Reset mid-transaction returns to ARB_IDLE immediately. The bridge must be reset in the same domain.

Decomposition:
- Package axi_bridge_arb_pkg holds:
  - state enum arb_state_t {ARB_IDLE, ARB_BUSY}
  - localparam function for the id width
- Sub-module rr_pick: purely combinational round-robin selector. Inputs: req vector, rr_ptr. Outputs: winner index, any_valid.

Test Plan:
1. Single write, NUM_REQ=3: s_req[1]=1, we=1, addr=0x1000_0040, wdata=0xDEADBEEF; bridge acks 4 cycles after m_req.
   -> m_req rises 1 cycle after s_req, m_addr/m_wdata match requester 1. s_ack=3'b010 for exactly one cycle. grant_id=1, then rr_ptr=2.
2. All three requesters hold s_req continuously; each bridge ack returns after 3 cycles.
   -> grants go 0,1,2,0. m_req is low for exactly 1 cycle between transactions. No requester is granted twice before the others.
3. Read on requester 2 with m_rdata=0x1234_5678 at ack.
   -> s_rdata=0x12345678 and s_ack=3'b100 in the same cycle; s_rdata=0 on the following cycle.
4. Timeout, TIMEOUT=16: bridge withholds ack.
   -> timeout_err rises after 16 BUSY cycles, m_req stays 1. A late ack still produces s_ack. err_clr then clears the flag.
5. Granted requester 0 drops s_req 2 cycles into BUSY.
   -> m_req and m_addr are held until m_ack, and s_ack[0] still pulses.
6. rst asserted while BUSY (async, mid-cycle).
   -> m_req, busy and s_ack go 0 immediately. After release, a new s_req[2] is granted, since rr_ptr=0 and only requester 2 is requesting.
